// File: rtl/btn_pkg.sv
// Shared types and defaults for the pushbutton front end.
package btn_pkg;
  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} state_t;

  localparam int DEBOUNCE_CYCLES_DEF = 500000;
  localparam int LONG_CYCLES_DEF     = 50000000;
  localparam int CNT_W               = 8;
endpackage

// File: rtl/button_toggle_if.sv
// Raw button pin in, clean button events and LED state out.
interface button_toggle_if;
  import btn_pkg::*;

  logic             btn;
  logic             led;
  logic             btn_level;
  logic             press_pulse;
  logic             release_pulse;
  logic             long_pulse;
  logic [CNT_W-1:0] press_count;

  // master: board/pin side; slave: the debouncer
  modport master (output btn, input led, btn_level, press_pulse, release_pulse, long_pulse, press_count);
  modport slave  (input btn, output led, btn_level, press_pulse, release_pulse, long_pulse, press_count);
endinterface

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchroniser with a selectable reset level.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/button_toggle.sv
// Debounced pushbutton: press/release/long-press strobes, level, press count, toggling LED.
module button_toggle
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int LONG_CYCLES     = LONG_CYCLES_DEF,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  button_toggle_if.slave  bus
);
  localparam int DCNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam int HCNT_W = $clog2(LONG_CYCLES + 1);
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HCNT_W-1:0] HCNT_LONG = HCNT_W'(LONG_CYCLES - 1);
  localparam logic [HCNT_W-1:0] HCNT_MAX  = HCNT_W'(LONG_CYCLES);
  localparam logic              INACTIVE  = BTN_ACTIVE_LOW;

  state_t             state;
  logic [DCNT_W-1:0]  dcnt;
  logic [HCNT_W-1:0]  hcnt;
  logic               long_flag;
  logic               btn_s;
  logic               act;
  logic               led_r, level_r, press_r, release_r, long_r;
  logic [CNT_W-1:0]   count_r;

  // Flops come out of reset at the idle pin level so reset release looks like "not pressed".
  sync_2ff #(.RST_VAL(INACTIVE)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.btn),
    .q   (btn_s)
  );

  assign act = btn_s ^ INACTIVE;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      dcnt      <= '0;
      hcnt      <= '0;
      long_flag <= 1'b0;
      led_r     <= 1'b0;
      level_r   <= 1'b0;
      press_r   <= 1'b0;
      release_r <= 1'b0;
      long_r    <= 1'b0;
      count_r   <= '0;
    end else begin
      press_r   <= 1'b0;
      release_r <= 1'b0;
      long_r    <= 1'b0;
      case (state)
        IDLE: begin
          if (act) begin
            state <= PRESS_DB;
            dcnt  <= '0;
          end
        end
        PRESS_DB: begin
          if (!act) begin
            state <= IDLE;
            dcnt  <= '0;
          end else if (dcnt == DCNT_LAST) begin
            state     <= HELD;
            dcnt      <= '0;
            press_r   <= 1'b1;
            led_r     <= ~led_r;
            level_r   <= 1'b1;
            count_r   <= count_r + 1'b1;
            hcnt      <= '0;
            long_flag <= 1'b0;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        HELD: begin
          if (hcnt != HCNT_MAX) hcnt <= hcnt + 1'b1;
          // long_flag keeps the strobe to one per press even if hcnt lingers
          if (hcnt == HCNT_LONG && !long_flag) begin
            long_r    <= 1'b1;
            long_flag <= 1'b1;
          end
          if (!act) begin
            state <= RELEASE_DB;
            dcnt  <= '0;
          end
        end
        RELEASE_DB: begin
          if (act) begin
            state <= HELD;
            dcnt  <= '0;
          end else if (dcnt == DCNT_LAST) begin
            state     <= IDLE;
            dcnt      <= '0;
            release_r <= 1'b1;
            level_r   <= 1'b0;
            hcnt      <= '0;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.led           = led_r;
  assign bus.btn_level     = level_r;
  assign bus.press_pulse   = press_r;
  assign bus.release_pulse = release_r;
  assign bus.long_pulse    = long_r;
  assign bus.press_count   = count_r;
endmodule

// File: tb/tb_button_toggle.sv
// Directed and random stimulus for button_toggle against a run-length reference model.
module tb_button_toggle;
  import btn_pkg::*;

  localparam int DEB  = 4;
  localparam int LONG = 20;
  localparam bit AL   = 1'b1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  button_toggle_if bus();

  button_toggle #(
    .DEBOUNCE_CYCLES (DEB),
    .LONG_CYCLES     (LONG),
    .BTN_ACTIVE_LOW  (AL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: pressed/released plus length of the current run of "opposite" samples.
  logic       q_pin[$];
  bit         m_pressed, m_led, m_ep, m_er, m_el, m_long_done;
  int         m_run, m_hold;
  logic [7:0] m_count;

  // Observed-event bookkeeping for timing checks.
  int cyc, n_press, n_release, n_long, last_press, last_release, last_long;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q_pin = {};
    q_pin.push_back(AL);
    q_pin.push_back(AL);
    m_pressed = 0; m_led = 0; m_ep = 0; m_er = 0; m_el = 0; m_long_done = 0;
    m_run = 0; m_hold = 0; m_count = '0;
  endtask

  // One clock edge: decisions use the pin value sampled two edges earlier.
  task automatic model_edge(input logic b);
    bit a, holding;
    q_pin.push_back(b);
    a = (q_pin[0] != AL);
    void'(q_pin.pop_front());
    m_ep = 0; m_er = 0; m_el = 0;
    if (!m_pressed) begin
      if (a) begin
        m_run++;
        if (m_run == DEB + 1) begin
          m_pressed = 1; m_run = 0; m_ep = 1; m_led = !m_led;
          m_count = m_count + 8'd1; m_hold = 0; m_long_done = 0;
        end
      end else m_run = 0;
    end else begin
      holding = (m_run == 0);
      if (holding) begin
        if (m_hold == LONG - 1 && !m_long_done) begin
          m_el = 1; m_long_done = 1;
        end
        if (m_hold < LONG) m_hold++;
      end
      if (!a) begin
        m_run++;
        if (m_run == DEB + 1) begin
          m_pressed = 0; m_run = 0; m_er = 1; m_hold = 0;
        end
      end else m_run = 0;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_led"},   bus.led, 0);
    chk({tag, "_lvl"},   bus.btn_level, 0);
    chk({tag, "_press"}, bus.press_pulse, 0);
    chk({tag, "_rel"},   bus.release_pulse, 0);
    chk({tag, "_long"},  bus.long_pulse, 0);
    chk({tag, "_cnt"},   bus.press_count, 0);
  endtask

  task automatic step(input logic b);
    bus.btn = b;
    @(posedge clk);
    model_edge(b);
    cyc++;
    #1;
    chk("led",        bus.led, m_led);
    chk("btn_level",  bus.btn_level, m_pressed);
    chk("press",      bus.press_pulse, m_ep);
    chk("release",    bus.release_pulse, m_er);
    chk("long",       bus.long_pulse, m_el);
    chk("count",      bus.press_count, m_count);
    chk("exclusive",  bus.press_pulse & bus.release_pulse, 0);
    if (bus.press_pulse === 1'b1)   begin n_press++;   last_press   = cyc; end
    if (bus.release_pulse === 1'b1) begin n_release++; last_release = cyc; end
    if (bus.long_pulse === 1'b1)    begin n_long++;    last_long    = cyc; end
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    bus.btn = AL;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("rst_hold");
    model_reset();
    rst = 1'b1;
  endtask

  initial begin
    int c0, p0, r0, l0;
    bus.btn = AL;
    cyc = 0; n_press = 0; n_release = 0; n_long = 0;
    last_press = 0; last_release = 0; last_long = 0;
    model_reset();

    // 1: reset, then idle
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b1;
    repeat (30) step(AL);
    chk("idle_no_press", n_press, 0);
    chk("idle_no_release", n_release, 0);
    chk("idle_no_long", n_long, 0);

    // 2: clean press; the change is sampled at edge 1, pulse DEB+2 edges after that
    c0 = cyc; p0 = n_press;
    repeat (10) step(~AL);
    chk("press_once", n_press - p0, 1);
    chk("press_latency", last_press - c0, 1 + DEB + 2);
    chk("press_led", bus.led, 1);
    chk("press_level", bus.btn_level, 1);
    chk("press_count1", bus.press_count, 1);
    repeat (10) step(AL);
    chk("press_released", bus.btn_level, 0);

    // 3: bounce rejection
    reset_dut();
    p0 = n_press; r0 = n_release;
    step(~AL); step(~AL); step(AL); step(~AL); step(~AL);
    repeat (10) step(AL);
    chk("bounce_no_press", n_press - p0, 0);
    chk("bounce_no_release", n_release - r0, 0);
    chk("bounce_led", bus.led, 0);
    chk("bounce_count", bus.press_count, 0);

    // 4: long press, release with one-cycle glitch
    reset_dut();
    l0 = n_long; p0 = n_press;
    repeat (40) step(~AL);
    chk("long_once", n_long - l0, 1);
    chk("long_press_once", n_press - p0, 1);
    chk("long_delay", last_long - last_press, LONG);
    c0 = cyc; r0 = n_release;
    step(AL); step(AL); step(~AL);
    repeat (10) step(AL);
    chk("glitch_release_once", n_release - r0, 1);
    // glitch reaches the FSM at edge 5; then DEB+1 clean inactive samples
    chk("glitch_release_time", last_release - c0, 5 + DEB + 1);
    chk("glitch_level", bus.btn_level, 0);
    chk("glitch_long_once", n_long - l0, 1);

    // 5: 256 presses wrap the counter
    reset_dut();
    p0 = n_press;
    for (int i = 0; i < 256; i++) begin
      repeat (8) step(~AL);
      repeat (8) step(AL);
      if (i == 254) chk("wrap_255", bus.press_count, 255);
    end
    chk("wrap_presses", n_press - p0, 256);
    chk("wrap_count", bus.press_count, 0);
    chk("wrap_led", bus.led, 0);

    // 6: asynchronous reset while held at hcnt = 10
    reset_dut();
    repeat (17) step(~AL);
    chk("pre_reset_level", bus.btn_level, 1);
    #2;
    rst = 1'b0;
    #1;
    chk_zero("async_reset");
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_zero("async_reset_hold");
    rst = 1'b1;
    c0 = cyc; p0 = n_press;
    repeat (10) step(~AL);
    chk("rearm_press_once", n_press - p0, 1);
    chk("rearm_latency", last_press - c0, 1 + DEB + 2);
    chk("rearm_count", bus.press_count, 1);
    repeat (10) step(AL);

    // random bounce/hold patterns against the model
    reset_dut();
    for (int s = 0; s < 80; s++) begin
      logic lvl;
      int len;
      lvl = logic'($urandom_range(0, 1));
      len = ($urandom_range(0, 7) == 0) ? $urandom_range(LONG, LONG + 10)
                                        : $urandom_range(1, 2 * DEB + 2);
      repeat (len) step(lvl);
    end
    repeat (12) step(AL);
    chk("random_final_level", bus.btn_level, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
